cache_bus1_slave: RTL and testbench



---
 rtl/bus1_pkg.sv | 43 ++++
 rtl/cache_bus1_slave_if.sv | 43 ++++
 rtl/cache_bus1_slave.sv | 144 ++++++++++++++
 tb/tb_cache_bus1_slave.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus1_pkg.sv
// Shared types, widths and helpers for the CPU bus-1 front end.
// Imported by the request interface and by cache_bus1_slave.
package bus1_pkg;

  localparam int TAG_W = 10;
  localparam int SET_W = 5;
  localparam int OFF_W = 4;
  localparam int A1_W  = 15;
  localparam int D1_W  = 16;
  localparam int C1_W  = 3;
  localparam int WD_W  = 32;

  typedef enum logic [2:0] {
    C1_NOP        = 3'd0,
    C1_READ8      = 3'd1,
    C1_READ16     = 3'd2,
    C1_READ32     = 3'd3,
    C1_INVALIDATE = 3'd4,
    C1_WRITE8     = 3'd5,
    C1_WRITE16    = 3'd6,
    C1_WRITE32    = 3'd7
  } c1_cmd_t;

  // When this block drives C1, code 7 means C1_RESPONSE.
  localparam c1_cmd_t C1_RESPONSE = C1_WRITE32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_ISSUE,
    S_WAIT,
    S_TURN,
    S_RESP1,
    S_RESP2
  } state_t;

  function automatic logic [15:0] bswap16(
    input logic [15:0] x
  );
    return {x[7:0], x[15:8]};
  endfunction

endpackage

// File: rtl/cache_bus1_slave_if.sv
// Request/response channel between the bus-1 front end and
// the cache core.
interface cache_bus1_slave_if #(
  parameter int TAG_W = bus1_pkg::TAG_W,
  parameter int SET_W = bus1_pkg::SET_W,
  parameter int OFF_W = bus1_pkg::OFF_W
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_cmd;
  logic [TAG_W-1:0] req_tag;
  logic [SET_W-1:0] req_set;
  logic [OFF_W-1:0] req_offset;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic [31:0]      resp_rdata;

  modport master (
    output req_valid,
    output req_cmd,
    output req_tag,
    output req_set,
    output req_offset,
    output req_wdata,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_cmd,
    input  req_tag,
    input  req_set,
    input  req_offset,
    input  req_wdata,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );

endinterface

// File: rtl/cache_bus1_slave.sv
// Bus-1 slave: decodes the two-tact command phase, issues one
// request to the cache core and drives the C1_RESPONSE phase.
module cache_bus1_slave
  import bus1_pkg::*;
#(
  parameter int CACHE_TAG_SIZE    = TAG_W,
  parameter int CACHE_SET_SIZE    = SET_W,
  parameter int CACHE_OFFSET_SIZE = OFF_W,
  parameter int ADDR1_BUS_SIZE    = A1_W,
  parameter int DATA1_BUS_SIZE    = D1_W,
  parameter int CTR1_BUS_SIZE     = C1_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR1_BUS_SIZE-1:0] a1_in,
  input  logic [DATA1_BUS_SIZE-1:0] d1_in,
  input  logic [CTR1_BUS_SIZE-1:0]  c1_in,
  output logic [DATA1_BUS_SIZE-1:0] d1_out,
  output logic                      d1_oe,
  output logic [CTR1_BUS_SIZE-1:0]  c1_out,
  output logic                      c1_oe,
  cache_bus1_slave_if.master        core
);

  localparam int TS = CACHE_TAG_SIZE;
  localparam int SS = CACHE_SET_SIZE;
  localparam int OS = CACHE_OFFSET_SIZE;

  state_t  state, state_nx;
  c1_cmd_t cmd;

  logic [TS-1:0]             tag;
  logic [SS-1:0]             set;
  logic [OS-1:0]             offset;
  logic [DATA1_BUS_SIZE-1:0] dlo;
  logic [DATA1_BUS_SIZE-1:0] dhi;
  logic [31:0]               rdata;
  logic                      is_read;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cmd    <= C1_NOP;
      tag    <= '0;
      set    <= '0;
      offset <= '0;
      dlo    <= '0;
      dhi    <= '0;
      rdata  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (c1_in != '0) begin
            cmd    <= c1_cmd_t'(c1_in);
            tag    <= a1_in[TS+SS-1:SS];
            set    <= a1_in[SS-1:0];
            dlo    <= d1_in;
            offset <= '0;
            dhi    <= '0;
          end
        end
        S_ADDR2: begin
          offset <= a1_in[OS-1:0];
          dhi    <= d1_in;
        end
        S_WAIT: begin
          if (core.resp_valid) rdata <= core.resp_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (c1_in != '0)
          state_nx = (c1_in == C1_INVALIDATE) ? S_ISSUE : S_ADDR2;
      end
      S_ADDR2: state_nx = S_ISSUE;
      S_ISSUE: if (core.req_ready) state_nx = S_WAIT;
      S_WAIT:  if (core.resp_valid) state_nx = S_TURN;
      S_TURN:  state_nx = S_RESP1;
      S_RESP1: state_nx = (cmd == C1_READ32) ? S_RESP2 : S_IDLE;
      S_RESP2: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign is_read = (cmd == C1_READ8) || (cmd == C1_READ16) ||
                   (cmd == C1_READ32);

  always_comb begin
    d1_out = '0;
    d1_oe  = 1'b0;
    c1_out = '0;
    c1_oe  = 1'b0;
    unique case (state)
      S_RESP1: begin
        c1_oe  = 1'b1;
        c1_out = C1_RESPONSE;
        d1_oe  = is_read;
        unique case (1'b1)
          cmd == C1_READ8:  d1_out = {8'h00, rdata[7:0]};
          cmd == C1_READ16,
          cmd == C1_READ32: d1_out = bswap16(rdata[15:0]);
          default:          d1_out = '0;
        endcase
      end
      S_RESP2: begin
        c1_oe  = 1'b1;
        c1_out = C1_RESPONSE;
        d1_oe  = 1'b1;
        d1_out = bswap16(rdata[31:16]);
      end
      default: ;
    endcase
  end

  always_comb begin
    core.req_wdata = '0;
    unique case (1'b1)
      cmd == C1_WRITE8:  core.req_wdata = {24'h0, dlo[7:0]};
      cmd == C1_WRITE16: core.req_wdata = {16'h0, bswap16(dlo)};
      cmd == C1_WRITE32: core.req_wdata = {bswap16(dhi), bswap16(dlo)};
      default:           core.req_wdata = '0;
    endcase
  end

  assign core.req_valid  = (state == S_ISSUE);
  assign core.req_cmd    = cmd;
  assign core.req_tag    = tag;
  assign core.req_set    = set;
  assign core.req_offset = offset;

  // Our own C1_RESPONSE drive is visible on c1_in, so skip those tacts.
  c1_quiet_outside_idle: assert property (
    @(posedge clk) disable iff (reset)
    (state != S_IDLE && !c1_oe) |-> (c1_in == '0)
  );

endmodule

// File: tb/tb_cache_bus1_slave.sv
// Directed and random transactions on bus 1 against a
// byte-level reference model of the front end.
module tb_cache_bus1_slave;
  import bus1_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] a1_in;
  logic [15:0] d1_in;
  logic [2:0]  c1_in;
  logic [15:0] d1_out;
  logic        d1_oe;
  logic [2:0]  c1_out;
  logic        c1_oe;

  int vectors = 0;
  int miscompares = 0;

  cache_bus1_slave_if bif ();

  cache_bus1_slave dut (
    .clk    (clk),
    .reset  (reset),
    .a1_in  (a1_in),
    .d1_in  (d1_in),
    .c1_in  (c1_in),
    .d1_out (d1_out),
    .d1_oe  (d1_oe),
    .c1_out (c1_out),
    .c1_oe  (c1_oe),
    .core   (bif)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sw(input logic [15:0] x);
    return ((x & 16'h00ff) << 8) | (x >> 8);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] c,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
    case (c)
      3'd5:    return 32'(lo) & 32'h0000_00ff;
      3'd6:    return 32'(sw(lo));
      3'd7:    return (32'(sw(hi)) << 16) + 32'(sw(lo));
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [15:0] exp_word(input logic [2:0] c,
                                           input logic [31:0] rd,
                                           input int idx);
    case (c)
      3'd1:    return 16'(rd % 256);
      3'd2:    return sw(16'(rd % 65536));
      3'd3:    return (idx == 0) ? sw(16'(rd % 65536))
                                 : sw(16'(rd / 65536));
      default: return 16'h0;
    endcase
  endfunction

  task automatic quiet(input string name);
    check(name, {29'h0, bif.req_valid, c1_oe, d1_oe}, 32'h0);
  endtask

  task automatic run_txn(input logic [2:0]  c,
                         input logic [9:0]  tg,
                         input logic [4:0]  st,
                         input logic [3:0]  off,
                         input logic [15:0] lo,
                         input logic [15:0] hi,
                         input int          rdly,
                         input int          wdly,
                         input logic        spur,
                         input logic [31:0] rd);
    logic [31:0] wd;
    logic        rdc;
    wd  = exp_wdata(c, lo, hi);
    rdc = (c >= 3'd1) && (c <= 3'd3);
    step();
    c1_in = c;
    a1_in = {tg, st};
    d1_in = lo;
    @(negedge clk);
    quiet("cmd_tact");
    if (c != 3'd4) begin
      step();
      c1_in = 3'd0;
      a1_in = 15'($urandom);
      a1_in[3:0] = off;
      d1_in = hi;
      @(negedge clk);
      quiet("addr_tact");
    end
    step();
    c1_in = 3'd0;
    a1_in = 15'($urandom);
    d1_in = 16'($urandom);
    for (int i = 0; i <= rdly; i++) begin
      if (i == rdly) begin
        bif.req_ready = 1'b1;
        if (spur) begin
          bif.resp_valid = 1'b1;
          bif.resp_rdata = 32'($urandom);
        end
      end
      @(negedge clk);
      check("req_valid", 32'(bif.req_valid), 32'h1);
      check("req_cmd", 32'(bif.req_cmd), 32'(c));
      check("req_tag", 32'(bif.req_tag), 32'(tg));
      check("req_set", 32'(bif.req_set), 32'(st));
      if (c != 3'd4)
        check("req_offset", 32'(bif.req_offset), 32'(off));
      if (c >= 3'd5)
        check("req_wdata", bif.req_wdata, wd);
      check("issue_oe", {30'h0, c1_oe, d1_oe}, 32'h0);
      step();
    end
    bif.req_ready  = 1'b0;
    bif.resp_valid = 1'b0;
    for (int i = 0; i <= wdly; i++) begin
      if (i == wdly) begin
        bif.resp_valid = 1'b1;
        bif.resp_rdata = rd;
      end
      @(negedge clk);
      quiet("wait_quiet");
      step();
    end
    bif.resp_valid = 1'b0;
    bif.resp_rdata = 32'($urandom);
    @(negedge clk);
    quiet("turn_quiet");
    step();
    @(negedge clk);
    check("resp1_c1_oe", 32'(c1_oe), 32'h1);
    check("resp1_c1_out", 32'(c1_out), 32'h7);
    check("resp1_d1_oe", 32'(d1_oe), 32'(rdc));
    if (rdc)
      check("resp1_d1_out", 32'(d1_out), 32'(exp_word(c, rd, 0)));
    step();
    if (c == 3'd3) begin
      @(negedge clk);
      check("resp2_c1_oe", 32'(c1_oe), 32'h1);
      check("resp2_c1_out", 32'(c1_out), 32'h7);
      check("resp2_d1_oe", 32'(d1_oe), 32'h1);
      check("resp2_d1_out", 32'(d1_out), 32'(exp_word(c, rd, 1)));
      step();
    end
    @(negedge clk);
    quiet("released");
  endtask

  initial begin
    reset = 1'b1;
    a1_in = '0;
    d1_in = '0;
    c1_in = '0;
    bif.req_ready  = 1'b0;
    bif.resp_valid = 1'b0;
    bif.resp_rdata = '0;
    repeat (3) step();
    @(negedge clk);
    quiet("reset_oe");
    check("reset_fields",
          {bif.req_cmd, bif.req_tag, bif.req_set, bif.req_offset},
          32'h0);
    check("reset_wdata", bif.req_wdata, 32'h0);
    check("reset_d1c1", {13'h0, c1_out, d1_out}, 32'h0);
    reset = 1'b0;

    run_txn(3'd7, 10'h2AA, 5'd5, 4'd5, 16'h7856, 16'h3412,
            0, 0, 1'b0, 32'h0);
    check("w32_model", exp_wdata(3'd7, 16'h7856, 16'h3412),
          32'h1234_5678);
    run_txn(3'd3, 10'h155, 5'd10, 4'd0, 16'h0, 16'h0,
            0, 2, 1'b0, 32'h1234_5678);
    run_txn(3'd1, 10'h001, 5'd31, 4'd15, 16'h0, 16'h0,
            1, 0, 1'b0, 32'h0000_0009);
    run_txn(3'd2, 10'h3FF, 5'd0, 4'd2, 16'h0, 16'h0,
            0, 1, 1'b0, 32'h0000_1389);
    run_txn(3'd4, 10'h2AA, 5'd5, 4'd0, 16'hBEEF, 16'h0,
            0, 0, 1'b0, 32'hDEAD_BEEF);
    run_txn(3'd6, 10'h123, 5'd7, 4'd8, 16'hA55A, 16'h0,
            5, 10, 1'b0, 32'h0);
    run_txn(3'd5, 10'h0F0, 5'd3, 4'd1, 16'hC3E1, 16'h0,
            0, 0, 1'b1, 32'h0);
    run_txn(3'd3, 10'h0AB, 5'd1, 4'd4, 16'h0, 16'h0,
            2, 0, 1'b1, 32'hCAFE_F00D);

    // Reset while the core owes a READ32 response.
    step();
    c1_in = 3'd3;
    a1_in = {10'h111, 5'd2};
    d1_in = '0;
    step();
    c1_in = 3'd0;
    a1_in = 15'd6;
    step();
    bif.req_ready = 1'b1;
    @(negedge clk);
    check("rst_issue", 32'(bif.req_valid), 32'h1);
    step();
    bif.req_ready = 1'b0;
    reset = 1'b1;
    bif.resp_valid = 1'b1;
    bif.resp_rdata = 32'h5555_AAAA;
    step();
    reset = 1'b0;
    bif.resp_valid = 1'b0;
    @(negedge clk);
    quiet("rst_abort");
    check("rst_tag", 32'(bif.req_tag), 32'h0);
    check("rst_cmd", 32'(bif.req_cmd), 32'h0);
    repeat (3) begin
      step();
      @(negedge clk);
      quiet("rst_dropped");
    end
    run_txn(3'd2, 10'h222, 5'd9, 4'd3, 16'h0, 16'h0,
            0, 0, 1'b0, 32'h0000_4321);

    for (int n = 0; n < 25; n++) begin
      run_txn(3'($urandom_range(1, 7)), 10'($urandom),
              5'($urandom), 4'($urandom), 16'($urandom),
              16'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom),
              32'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
